fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
//  Instruction-side front end of the RV32I core. Fetches 32-bit words from instruction memory over a req/ack handshake.
//  Latches each word in an instruction register (IR) and decodes it into the ALU control/operand-select bundle
//  (ALU_source, opcode, funct3, funct7, immediate) and register addresses.
//  Consumes the ALU's branch/result outputs to compute the next PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset
// PORTS
//  clk          in   1   system clock, rising edge
//  nRst         in   1   asynchronous active-low reset
//  imem_req     out  1   fetch request; held until imem_ack
//  imem_addr    out  32  fetch address (= pc), stable while imem_req=1
//  imem_ack     in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  stall        in   1   data-side busy; holds the current instruction in EXEC
//  alu_branch   in   1   ALU branch-taken flag (B-type, JAL, JALR)
//  alu_result   in   32  ALU result; JALR target
//  instr_valid  out  1   decoded bundle valid (EXEC state)
//  pc           out  32  address of the instruction in IR
//  ALU_source   out  1   0: reg2 operand, 1: immediate operand
//  opcode       out  7   IR[6:0]
//  funct3       out  3   IR[14:12]
//  funct7       out  7   IR[31:25]; forced 0 for non-R/non-shift-imm
//  immediate    out  32  sign-extended I/S/B/J imm; U: {IR[31:12],12'b0}
//  rs1,rs2,rd   out  5   register addresses; rd=0 for S/B-type
//  reg_write    out  1   rd write enable (R, I, load, JAL, JALR, LUI, AUIPC)
//  mem_read     out  1   load opcode 0000011
//  mem_write    out  1   store opcode 0100011
//  illegal      out  1   IR opcode not in RV32I base set
// BEHAVIOUR
//  - States: IDLE (reset state) -> FETCH -> EXEC -> FETCH; HALT only with the macro.
//  - IDLE: one cycle, then FETCH.
//  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: IR <= imem_rdata, go to EXEC.
//    imem_ack is ignored outside FETCH.
//  - EXEC: instr_valid=1; decoded outputs are combinational from IR.
//    If stall=1, stay in EXEC with all outputs held.
//    If stall=0: pc <= next_pc, go to FETCH. Minimum 2 cycles per instruction.
//  - next_pc:
//    - JAL: pc+imm.
//    - JALR: {alu_result[31:1],1'b0}.
//    - B-type: alu_branch ? pc+imm : pc+4.
//    - All others: pc+4.
//    - Bits [1:0] forced to 00 in every case; 32-bit wrap-around on overflow, no flag.
//  - ALU_source=1 for I-ALU, load, store, JALR, LUI, AUIPC; 0 for R and B.
//  - Illegal opcode: illegal=1, reg_write/mem_read/mem_write=0; next_pc=pc+4.
//  - Reset (async, any state, including mid-handshake):
//    - pc=RESET_PC, IR=32'h0000_0013 (NOP), state=IDLE.
//    - imem_req=0, instr_valid=0, illegal=0; all decode outputs reflect the NOP.
// CONFIGURATION
//  FETCH_ILLEGAL_HALT_EN defined:
//    - Illegal opcode in EXEC moves the FSM to HALT. HALT is left only by reset.
//    - In HALT: imem_req=0, instr_valid=0, illegal held 1, pc frozen.
//  Undefined: illegal opcode executes as a NOP and fetch continues at pc+4.
// STRUCTURE
//  - rv32i_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC),
//    fsm_state_t enum, imm_type_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}.
//  - Sub-module imm_gen: combinational; IR + imm_type_t -> 32-bit immediate.
// TESTING
//  - Reset, then imem_ack after 3 wait cycles with 0x00500093 (addi x1,x0,5):
//    imem_req held 4 cycles; EXEC shows imm=5, rd=1, rs1=0, ALU_source=1, reg_write=1; pc then becomes 4.
//  - 0x002081B3 (add x3,x1,x2) with stall=1 for 2 cycles:
//    instr_valid held 3 cycles, rs1=1, rs2=2, rd=3, ALU_source=0, pc advances only after stall drops.
//  - 0x00000463 (beq +8) at pc=0x10:
//    alu_branch=1 gives next pc 0x18; alu_branch=0 gives next pc 0x14.
//  - 0x123452B7 (lui x5): imm=0x12345000, rd=5.
//    0x010000EF (jal +16) at pc=0x20: next pc 0x30.
//    JALR with alu_result=0x0000_0105: next pc 0x104.
//  - Word 0xFFFFFFFF: illegal=1, no write enables.
//    Next pc+4 without the macro; HALT with imem_req=0 with FETCH_ILLEGAL_HALT_EN.
//    nRst pulse mid-FETCH: imem_req drops immediately, pc=RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch/decode front end: base opcodes,
// controller states and immediate encodings.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // addi x0,x0,0 -- what the instruction register holds out of reset
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fsm_state_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: reassembles and sign-extends the RV32I immediate
// fields of an instruction word according to its encoding format.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] instr_i,
  input  imm_type_t   imm_type_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = 32'h0;
    case (imm_type_i)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'h000};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// RV32I fetch/decode front end: fetches over a req/ack handshake, decodes the IR
// and computes the next PC. Define FETCH_ILLEGAL_HALT_EN to halt on an illegal opcode.
module fetch_decode_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        alu_branch,
  input  logic [31:0] alu_result,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        ALU_source,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] immediate,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  fsm_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  imm_type_t   immType;
  logic        hasImm;
  logic [31:0] immRaw;
  logic [31:0] nextPcRaw;
  logic [31:0] nextPc;

  imm_gen u_imm_gen (
    .instr_i    (ir_q[31:7]),
    .imm_type_i (immType),
    .imm_o      (immRaw)
  );

  always_comb begin
    immType    = IMM_I;
    hasImm     = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ALU_source = 1'b0;
    illegal    = 1'b0;
    case (ir_q[6:0])
      OP_R:      reg_write = 1'b1;
      OP_IMM:    begin reg_write = 1'b1; ALU_source = 1'b1; hasImm = 1'b1; end
      OP_LOAD:   begin reg_write = 1'b1; mem_read = 1'b1; ALU_source = 1'b1; hasImm = 1'b1; end
      OP_STORE:  begin mem_write = 1'b1; ALU_source = 1'b1; hasImm = 1'b1; immType = IMM_S; end
      OP_BRANCH: begin hasImm = 1'b1; immType = IMM_B; end
      OP_JAL:    begin reg_write = 1'b1; hasImm = 1'b1; immType = IMM_J; end
      OP_JALR:   begin reg_write = 1'b1; ALU_source = 1'b1; hasImm = 1'b1; end
      OP_LUI,
      OP_AUIPC:  begin reg_write = 1'b1; ALU_source = 1'b1; hasImm = 1'b1; immType = IMM_U; end
      default:   illegal = 1'b1;
    endcase
  end

  // funct7 only carries meaning for R-type and the immediate shifts (funct3 001/101)
  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ((ir_q[6:0] == OP_R) || ((ir_q[6:0] == OP_IMM) && (ir_q[13:12] == 2'b01)))
                     ? ir_q[31:25] : 7'h00;
  assign immediate = hasImm ? immRaw : 32'h0;
  assign rs1       = ir_q[19:15];
  assign rs2       = ir_q[24:20];
  assign rd        = ((ir_q[6:0] == OP_STORE) || (ir_q[6:0] == OP_BRANCH)) ? 5'd0 : ir_q[11:7];

  always_comb begin
    nextPcRaw = pc_q + 32'd4;
    case (ir_q[6:0])
      OP_JAL:    nextPcRaw = pc_q + immediate;
      OP_JALR:   nextPcRaw = alu_result;
      OP_BRANCH: nextPcRaw = alu_branch ? (pc_q + immediate) : (pc_q + 32'd4);
      default:   nextPcRaw = pc_q + 32'd4;
    endcase
  end

  // Word alignment is enforced here for every target, which also clears the JALR lsb
  assign nextPc = nextPcRaw & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
`ifdef FETCH_ILLEGAL_HALT_EN
          if (illegal) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = nextPc;
            state_d = ST_FETCH;
          end
`else
          pc_d    = nextPc;
          state_d = ST_FETCH;
`endif
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == ST_EXEC);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed, table-driven bench for fetch_decode_unit: walks a program through
// the fetch handshake and checks decode outputs and next-PC selection.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        nRst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        alu_branch;
  logic [31:0] alu_result;
  logic        instr_valid;
  logic [31:0] pc;
  logic        ALU_source;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immediate;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, mem_read, mem_write, illegal;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] instr;
    logic        br;
    logic [31:0] res;
    logic [31:0] expImm;
    logic [4:0]  expRd;
    logic [4:0]  expRs1;
    logic        expSrc;
    logic        expRw;
    logic        expMr;
    logic        expMw;
    logic [6:0]  expF7;
    logic [31:0] expNext;
  } vec_t;

  fetch_decode_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .alu_branch  (alu_branch),
    .alu_result  (alu_result),
    .instr_valid (instr_valid),
    .pc          (pc),
    .ALU_source  (ALU_source),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .immediate   (immediate),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    nRst       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    alu_branch = 1'b0;
    alu_result = 32'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1 nRst = 1'b1;
    @(negedge clk);
  endtask

  // Waits for the fetch, answers after waitCycles, leaves the DUT in EXEC at a negedge
  task automatic applyStimulus(input logic [31:0] instr, input int waitCycles, input logic br,
                               input logic [31:0] res, input logic [31:0] expPc,
                               output int reqCycles);
    int guard = 0;
    reqCycles = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("fetchReqSeen", {31'h0, imem_req}, 32'h1);
    checkOutput("fetchAddr", imem_addr, expPc);
    for (int i = 0; i <= waitCycles; i++) begin
      if (imem_req === 1'b1) reqCycles++;
      if (i == waitCycles) begin
        imem_ack   = 1'b1;
        imem_rdata = instr;
      end
      @(negedge clk);
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    alu_branch = br;
    alu_result = res;
    checkOutput("execValid", {31'h0, instr_valid}, 32'h1);
  endtask

  // Holds stall for stallCycles while offering a stray ack that must be ignored
  task automatic finishExec(input int stallCycles, input logic [31:0] heldPc, output int validCycles);
    logic [6:0] heldOp;
    heldOp      = opcode;
    validCycles = 0;
    for (int i = 0; i <= stallCycles; i++) begin
      if (instr_valid === 1'b1) validCycles++;
      if (i > 0) begin
        checkOutput("stallPcHeld", pc, heldPc);
        checkOutput("stallIrHeld", {25'h0, opcode}, {25'h0, heldOp});
      end
      stall      = (i < stallCycles);
      imem_ack   = (i < stallCycles);
      imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    alu_branch = 1'b0;
  endtask

  task automatic checkDecode(input string tag, input vec_t v);
    checkOutput({tag, ".imm"}, immediate, v.expImm);
    checkOutput({tag, ".rd"}, {27'h0, rd}, {27'h0, v.expRd});
    checkOutput({tag, ".rs1"}, {27'h0, rs1}, {27'h0, v.expRs1});
    checkOutput({tag, ".ctl"}, {28'h0, ALU_source, reg_write, mem_read, mem_write},
                {28'h0, v.expSrc, v.expRw, v.expMr, v.expMw});
    checkOutput({tag, ".funct7"}, {25'h0, funct7}, {25'h0, v.expF7});
    checkOutput({tag, ".illegal"}, {31'h0, illegal}, 32'h0);
  endtask

  initial begin
    vec_t vecs[12];
    vec_t hand;
    logic [31:0] expPc;
    int reqCycles;
    int validCycles;

    //           instr          br    res            imm            rd  rs1 src rw mr mw f7     next
    vecs[0]  = '{32'h0001_0067, 1'b0, 32'h0000_0010, 32'h0,         0,  2, 1, 1, 0, 0, 7'h00, 32'h0000_0010};
    vecs[1]  = '{32'h0000_0463, 1'b1, 32'h0,         32'h8,         0,  0, 0, 0, 0, 0, 7'h00, 32'h0000_0018};
    vecs[2]  = '{32'h0001_0067, 1'b0, 32'h0000_0010, 32'h0,         0,  2, 1, 1, 0, 0, 7'h00, 32'h0000_0010};
    vecs[3]  = '{32'h0000_0463, 1'b0, 32'h0,         32'h8,         0,  0, 0, 0, 0, 0, 7'h00, 32'h0000_0014};
    vecs[4]  = '{32'h1234_52B7, 1'b0, 32'h0,         32'h1234_5000, 5,  8, 1, 1, 0, 0, 7'h00, 32'h0000_0018};
    vecs[5]  = '{32'h0001_0067, 1'b0, 32'h0000_0020, 32'h0,         0,  2, 1, 1, 0, 0, 7'h00, 32'h0000_0020};
    vecs[6]  = '{32'h0100_00EF, 1'b1, 32'h0,         32'h10,        1,  0, 0, 1, 0, 0, 7'h00, 32'h0000_0030};
    vecs[7]  = '{32'h0001_0067, 1'b0, 32'h0000_0105, 32'h0,         0,  2, 1, 1, 0, 0, 7'h00, 32'h0000_0104};
    vecs[8]  = '{32'h0020_A223, 1'b0, 32'h0,         32'h4,         0,  1, 1, 0, 0, 1, 7'h00, 32'h0000_0108};
    vecs[9]  = '{32'hFFC0_A303, 1'b0, 32'h0,         32'hFFFF_FFFC, 6,  1, 1, 1, 1, 0, 7'h00, 32'h0000_010C};
    vecs[10] = '{32'h0001_0067, 1'b0, 32'hFFFF_FFFF, 32'h0,         0,  2, 1, 1, 0, 0, 7'h00, 32'hFFFF_FFFC};
    vecs[11] = '{32'h4030_D093, 1'b0, 32'h0,         32'h0000_0403, 1,  1, 1, 1, 0, 0, 7'h20, 32'h0000_0000};

    doReset();
    checkOutput("rstReq", {31'h0, imem_req}, 32'h0);
    checkOutput("rstValid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rstPc", pc, 32'h0);
    checkOutput("rstOpcode", {25'h0, opcode}, 32'h13);
    checkOutput("rstNopDecode", {immediate[7:0], 3'h0, rd, 3'h0, ALU_source, reg_write, illegal},
                {8'h00, 3'h0, 5'd0, 3'h0, 1'b1, 1'b1, 1'b0});
    releaseReset();
    checkOutput("idleNoReq", {31'h0, imem_req}, 32'h0);

    // addi x1,x0,5 answered after three wait cycles
    applyStimulus(32'h0050_0093, 3, 1'b0, 32'h0, 32'h0, reqCycles);
    checkOutput("addiReqCycles", reqCycles, 4);
    hand = '{32'h0050_0093, 1'b0, 32'h0, 32'h5, 1, 0, 1, 1, 0, 0, 7'h00, 32'h4};
    checkDecode("addi", hand);
    finishExec(0, 32'h0, validCycles);
    checkOutput("addiNextPc", pc, 32'h4);

    // add x3,x1,x2 held by two stall cycles
    applyStimulus(32'h0020_81B3, 0, 1'b0, 32'h0, 32'h4, reqCycles);
    checkOutput("addRs2", {27'h0, rs2}, 32'd2);
    checkOutput("addFunct3", {29'h0, funct3}, 32'h0);
    hand = '{32'h0020_81B3, 1'b0, 32'h0, 32'h0, 3, 1, 0, 1, 0, 0, 7'h00, 32'h8};
    checkDecode("add", hand);
    finishExec(2, 32'h4, validCycles);
    checkOutput("addValidCycles", validCycles, 3);
    checkOutput("addNextPc", pc, 32'h8);

    expPc = 32'h8;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].instr, i % 3, vecs[i].br, vecs[i].res, expPc, reqCycles);
      checkDecode($sformatf("vec%0d", i), vecs[i]);
      checkOutput($sformatf("vec%0d.pc", i), pc, expPc);
      finishExec(0, expPc, validCycles);
      checkOutput($sformatf("vec%0d.nextPc", i), pc, vecs[i].expNext);
      expPc = vecs[i].expNext;
    end

    // illegal word after the pc wrapped to zero
    applyStimulus(32'hFFFF_FFFF, 0, 1'b0, 32'h0, 32'h0, reqCycles);
    checkOutput("illegalFlag", {31'h0, illegal}, 32'h1);
    checkOutput("illegalNoWrites", {29'h0, reg_write, mem_read, mem_write}, 32'h0);
`ifdef FETCH_ILLEGAL_HALT_EN
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("haltState", {29'h0, imem_req, instr_valid, illegal}, 32'b001);
      checkOutput("haltPc", pc, 32'h0);
    end
`else
    finishExec(0, 32'h0, validCycles);
    checkOutput("illegalReq", {31'h0, imem_req}, 32'h1);
    checkOutput("illegalNextPc", imem_addr, 32'h4);
`endif

    // async reset pulse in the middle of a fetch handshake
    doReset();
    releaseReset();
    applyStimulus(32'h0050_0093, 0, 1'b0, 32'h0, 32'h0, reqCycles);
    finishExec(0, 32'h0, validCycles);
    checkOutput("preResetReq", {31'h0, imem_req}, 32'h1);
    checkOutput("preResetPc", pc, 32'h4);
    #2 nRst = 1'b0;
    #1;
    checkOutput("midFetchRstReq", {31'h0, imem_req}, 32'h0);
    checkOutput("midFetchRstPc", pc, 32'h0);
    checkOutput("midFetchRstNop", {27'h0, rd}, 32'h0);
    checkOutput("midFetchRstImm", immediate, 32'h0);
    repeat (2) @(negedge clk);
    releaseReset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
